// File: rtl/offset_dim_arbiter.sv
// Round-robin arbiter feeding a shared dimension-offset adder into a single-entry output register.
// Optional stall counter enabled with OFFSET_DIM_ARBITER_STATS_EN.
module offset_dim_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned HEIGHT  = 11,
  parameter int unsigned BASE_W  = 100,
  parameter int unsigned BASE_H  = 200
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_dx,
  input  logic [NUM_REQ*HEIGHT-1:0]    req_dy,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WIDTH-1:0]             resp_width,
  output logic [HEIGHT-1:0]            resp_height,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id
`ifdef OFFSET_DIM_ARBITER_STATS_EN
  ,
  input  logic                         stats_clear,
  output logic [15:0]                  stall_count
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  width_q, width_d;
  logic [HEIGHT-1:0] height_q, height_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;

  logic              found;
  logic [IDW-1:0]    winner;
  logic              can_accept;
  logic              grant;
  logic [WIDTH-1:0]  sel_dx;
  logic [HEIGHT-1:0] sel_dy;

  // Round-robin scan: first pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

  assign can_accept = enable & (~resp_valid | resp_ready);
  assign grant      = found & can_accept;

  // Operand mux for the shared adder and the one-hot accept.
  always_comb begin
    sel_dx    = '0;
    sel_dy    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_dx       = req_dx[i*WIDTH +: WIDTH];
        sel_dy       = req_dy[i*HEIGHT +: HEIGHT];
        req_ready[i] = grant;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL: begin
        if (grant)           state_d = ST_FULL;
        else if (resp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (grant) begin
      width_d  = WIDTH'(BASE_W) + sel_dx;
      height_d = HEIGHT'(BASE_H) + sel_dy;
      id_d     = winner;
      rr_ptr_d = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      width_q  <= '0;
      height_q <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign resp_valid  = (state_q == ST_FULL);
  assign resp_width  = width_q;
  assign resp_height = height_q;
  assign resp_id     = id_q;

`ifdef OFFSET_DIM_ARBITER_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the consumer back-pressures a held result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stats_clear) begin
      stall_q <= '0;
    end else if (resp_valid && !resp_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_offset_dim_arbiter.sv
// Bench for offset_dim_arbiter: directed vector table, async reset sequence, randomized run vs. reference model.
module tb_offset_dim_arbiter;

  localparam int N  = 2;
  localparam int W  = 10;
  localparam int H  = 11;
  localparam int BW = 100;
  localparam int BH = 200;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_dx;
  logic [N*H-1:0]   req_dy;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_width;
  logic [H-1:0]     resp_height;
  logic [0:0]       resp_id;
`ifdef OFFSET_DIM_ARBITER_STATS_EN
  logic             stats_clear;
  logic [15:0]      stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  offset_dim_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .HEIGHT(H), .BASE_W(BW), .BASE_H(BH)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dx(req_dx), .req_dy(req_dy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_width(resp_width), .resp_height(resp_height), .resp_id(resp_id)
`ifdef OFFSET_DIM_ARBITER_STATS_EN
    , .stats_clear(stats_clear), .stall_count(stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  v;
    logic [9:0]  dx0;
    logic [9:0]  dx1;
    logic [10:0] dy0;
    logic [10:0] dy1;
    logic        rr;
    logic        en;
    logic [1:0]  er;
    logic        ev;
    logic [9:0]  ew;
    logic [10:0] eh;
    logic        eid;
  } vec_t;

  vec_t tbl [15];

  // Reference model state
  int m_ptr;
  bit m_valid;
  int m_w, m_h, m_id;
  int m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic [9:0] dx0, input logic [9:0] dx1,
                       input logic [10:0] dy0, input logic [10:0] dy1, input logic rr, input logic en);
    req_valid  = v;
    req_dx     = {dx1, dx0};
    req_dy     = {dy1, dy0};
    resp_ready = rr;
    enable     = en;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_w = 0; m_h = 0; m_id = 0; m_stall = 0;
  endtask

  // One cycle against the model; called at posedge+1 with inputs already applied.
  task automatic rand_cycle();
    int win;
    int idx;
    bit can;
    logic [1:0] expr;
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    can  = enable && (!m_valid || resp_ready);
    expr = (win >= 0 && can) ? 2'(1 << win) : 2'b00;
    #3;
    chk("rnd_req_ready", 32'(req_ready), 32'(expr));
`ifdef OFFSET_DIM_ARBITER_STATS_EN
    if (stats_clear) m_stall = 0;
    else if (m_valid && !resp_ready && m_stall < 65535) m_stall++;
`endif
    if (win >= 0 && can) begin
      m_valid = 1;
      m_w     = (BW + int'(req_dx[win*W +: W])) % (1 << W);
      m_h     = (BH + int'(req_dy[win*H +: H])) % (1 << H);
      m_id    = win;
      m_ptr   = (win + 1) % N;
    end else if (resp_ready) begin
      m_valid = 0;
    end
    @(posedge clock);
    #1;
    chk("rnd_resp_valid", 32'(resp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rnd_resp_width", 32'(resp_width), 32'(m_w));
      chk("rnd_resp_height", 32'(resp_height), 32'(m_h));
      chk("rnd_resp_id", 32'(resp_id), 32'(m_id));
    end
`ifdef OFFSET_DIM_ARBITER_STATS_EN
    chk("rnd_stall_count", 32'(stall_count), 32'(m_stall));
`endif
  endtask

  initial begin
    tbl[0]  = '{2'b01, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b01, 1'b1, 10'd105, 11'd207, 1'b0};
    tbl[1]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b10, 1'b1, 10'd76,  11'd152, 1'b1};
    tbl[2]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b01, 1'b1, 10'd105, 11'd207, 1'b0};
    tbl[3]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b10, 1'b1, 10'd76,  11'd152, 1'b1};
    tbl[4]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b01, 1'b1, 10'd105, 11'd207, 1'b0};
    tbl[5]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b10, 1'b1, 10'd76,  11'd152, 1'b1};
    tbl[6]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b01, 1'b1, 10'd105, 11'd207, 1'b0};
    tbl[7]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b0, 1'b1, 2'b00, 1'b1, 10'd105, 11'd207, 1'b0};
    tbl[8]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b0, 1'b1, 2'b00, 1'b1, 10'd105, 11'd207, 1'b0};
    tbl[9]  = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b0, 1'b1, 2'b00, 1'b1, 10'd105, 11'd207, 1'b0};
    tbl[10] = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b10, 1'b1, 10'd76,  11'd152, 1'b1};
    tbl[11] = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b0, 1'b0, 2'b00, 1'b1, 10'd76,  11'd152, 1'b1};
    tbl[12] = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b0, 2'b00, 1'b0, 10'd0,   11'd0,   1'b0};
    tbl[13] = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b0, 2'b00, 1'b0, 10'd0,   11'd0,   1'b0};
    tbl[14] = '{2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1, 2'b01, 1'b1, 10'd105, 11'd207, 1'b0};

    reset = 1'b1;
`ifdef OFFSET_DIM_ARBITER_STATS_EN
    stats_clear = 1'b0;
`endif
    apply(2'b00, 10'd0, 10'd0, 11'd0, 11'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_width", 32'(resp_width), 32'd0);
    chk("reset_resp_height", 32'(resp_height), 32'd0);
    chk("reset_resp_id", 32'(resp_id), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].v, tbl[i].dx0, tbl[i].dx1, tbl[i].dy0, tbl[i].dy1, tbl[i].rr, tbl[i].en);
      #3;
      chk($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].er));
      @(posedge clock);
      #1;
      chk($sformatf("row%0d_resp_valid", i), 32'(resp_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_resp_width", i), 32'(resp_width), 32'(tbl[i].ew));
        chk($sformatf("row%0d_resp_height", i), 32'(resp_height), 32'(tbl[i].eh));
        chk($sformatf("row%0d_resp_id", i), 32'(resp_id), 32'(tbl[i].eid));
      end
`ifdef OFFSET_DIM_ARBITER_STATS_EN
      if (i == 9) chk("stall_after_3_holds", 32'(stall_count), 32'd3);
`endif
    end

    // Async reset between edges while a result is held
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("async_reset_resp_width", 32'(resp_width), 32'd0);
    chk("async_reset_resp_id", 32'(resp_id), 32'd0);
`ifdef OFFSET_DIM_ARBITER_STATS_EN
    chk("async_reset_stall", 32'(stall_count), 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply(2'b11, 10'd5, 10'd1000, 11'd7, 11'd2000, 1'b1, 1'b1);
    #3;
    chk("post_reset_grant", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    chk("post_reset_resp_id", 32'(resp_id), 32'd0);
    chk("post_reset_resp_width", 32'(resp_width), 32'd105);

`ifdef OFFSET_DIM_ARBITER_STATS_EN
    // Clear wins over an increment in the same cycle
    apply(2'b00, 10'd0, 10'd0, 11'd0, 11'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("stall_two_holds", 32'(stall_count), 32'd2);
    stats_clear = 1'b1;
    @(posedge clock);
    #1;
    stats_clear = 1'b0;
    chk("stall_clear_priority", 32'(stall_count), 32'd0);
`endif

    // Randomized run against the reference model
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    for (int c = 0; c < 400; c++) begin
      apply(2'($urandom), 10'($urandom), 10'($urandom), 11'($urandom), 11'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
`ifdef OFFSET_DIM_ARBITER_STATS_EN
      stats_clear = 1'($urandom_range(0, 19) == 0);
`endif
      rand_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/offset_dim_arbiter.md
Name: offset_dim_arbiter

Overview:
- Round-robin arbiter that shares one parameterized dimension-offset datapath among NUM_REQ requesters.
- The datapath computes width = BASE_W + dx and height = BASE_H + dy, truncated to WIDTH/HEIGHT bits.
- The block owns the grant decision, the single-entry output register and the valid/ready handshakes on both sides.
- It sits between requesting blocks and any consumer of the computed dimensions.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- WIDTH, 10, bit width of dx and resp_width.
- HEIGHT, 11, bit width of dy and resp_height.
- BASE_W, 100, width offset constant.
- BASE_H, 200, height offset constant.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, no new grants; any held response still drains.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot grant/accept; combinational.
- req_dx  input  NUM_REQ*WIDTH  flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- req_dy  input  NUM_REQ*HEIGHT  flattened; requester i occupies bits [i*HEIGHT +: HEIGHT].
- resp_valid  output  1  output register holds a result.
- resp_ready  input  1  consumer accepts the result.
- resp_width  output  WIDTH  BASE_W + dx, modulo 2^WIDTH.
- resp_height  output  HEIGHT  BASE_H + dy, modulo 2^HEIGHT.
- resp_id  output  $clog2(NUM_REQ)  index of the requester that produced the result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: resp_valid=0, resp_width=0, resp_height=0, resp_id=0, rr_ptr=0. An in-flight response is discarded.
- Output-register states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
  - EMPTY to FULL on a grant.
  - FULL stays FULL on resp_ready together with a grant; the register is overwritten with the new result.
  - FULL to EMPTY on resp_ready with no grant.
  - FULL holds with no grant when resp_ready=0; outputs stay stable.
- can_accept = enable & (!resp_valid | resp_ready).
- Grant selection:
  - Scan indices rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the first with req_valid=1 wins.
  - req_ready = one-hot(winner) & can_accept; all zeros if there is no winner or can_accept=0.
- On a grant at edge k:
  - resp_width, resp_height and resp_id load; resp_valid=1 after edge k (latency 1).
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no grant.
- Arithmetic: both operands are zero-extended to the result width; the carry is discarded. Example: WIDTH=10, dx=1000 gives (100+1000) mod 1024 = 76.
- Throughput: 1 result per cycle while resp_ready=1 and requests are present.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ grants.
- Requester contract: req_dx/req_dy must be stable while req_valid=1 and req_ready=0. A requester may withdraw req_valid; the arbiter keeps no memory of it.
- enable deasserted mid-stream: the held result still completes its handshake; no grant is issued while enable=0.
- Reset asserted mid-transfer: outputs clear immediately, independent of clock.
- No combinational path from req_valid to resp_valid. The combinational path resp_ready to req_ready is allowed and intended.

Optional Feature:
- Macro: OFFSET_DIM_ARBITER_STATS_EN.
- When defined, adds output stall_count [15:0]:
  - Increments each cycle resp_valid=1 & resp_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
  - Adds input stats_clear (1 bit), a synchronous clear that takes priority over increment.
- When not defined, neither port exists and there is no counter logic.

Test Plan:
- Reset, then req_valid=2'b01, dx=5, dy=7, resp_ready=1:
  - req_ready=2'b01 in the same cycle.
  - Next cycle resp_valid=1, resp_width=105, resp_height=207, resp_id=0.
- Both requesters continuously valid, resp_ready=1, 6 cycles:
  - Grants alternate 0,1,0,1,0,1.
  - resp_id sequence matches, one cycle later.
- Result held, then resp_ready=0 for 3 cycles with both requests valid:
  - req_ready=0 for those cycles.
  - resp_* stable.
  - With STATS_EN, stall_count=3.
  - Raise resp_ready: a grant occurs in that cycle.
- Overflow: dx=1000, dy=2000 (WIDTH=10, HEIGHT=11) -> resp_width=76, resp_height=152.
- enable=0 with requests pending and one result held:
  - Result drains on resp_ready.
  - resp_valid=0 next cycle; no req_ready asserted until enable=1.
- Assert reset asynchronously (between edges) while resp_valid=1:
  - resp_valid drops before the next edge.
  - After release, the first grant goes to requester 0 (rr_ptr=0).
